// File: rtl/layer_out_serializer.sv
// Collects one activation per neuron, then streams them in neuron-index order over valid/ready.
// Pulses that arrive while a frame is streaming are dropped and flagged in overflow.
module layer_out_serializer #(
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_NEURONS*IN_WIDTH-1:0] in_data,
    input  logic [NUM_NEURONS-1:0]          in_valid,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [IDX_WIDTH-1:0]            out_idx,
    output logic                            out_last,
    output logic                            frame_done,
    output logic                            overflow,
    input  logic                            clr_err
);

    typedef enum logic {StCollect, StSend} state_e;

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_NEURONS - 1);

    state_e                  state;
    logic [IN_WIDTH-1:0]     act_buf [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  mask;
    logic [NUM_NEURONS-1:0]  mask_next;
    logic [IDX_WIDTH-1:0]    rd_ptr;
    logic [IDX_WIDTH-1:0]    next_ptr;
    logic [IN_WIDTH-1:0]     first_word;
    logic                    xfer;
    logic                    final_xfer;
    logic                    capture;
    logic                    complete;
    logic                    drop;

    always_comb begin
        xfer       = (state == StSend) && out_valid && out_ready;
        final_xfer = xfer && (rd_ptr == LastIdx);
        // The final-transfer cycle already belongs to the next frame's collection window.
        capture    = (state == StCollect) || final_xfer;
        mask_next  = mask | in_valid;
        complete   = (state == StCollect) && (&mask_next);
        drop       = (state == StSend) && !final_xfer && (|in_valid);
        next_ptr   = rd_ptr + IDX_WIDTH'(1);
        // Bypass so a word captured on the completing edge is presented immediately.
        first_word = in_valid[0] ? in_data[IN_WIDTH-1:0] : act_buf[0];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (capture && in_valid[k]) begin
                act_buf[k] <= in_data[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StCollect;
            mask       <= '0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            unique case (state)
                StCollect: begin
                    if (complete) begin
                        state     <= StSend;
                        mask      <= '0;
                        rd_ptr    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= OUT_WIDTH'(first_word);
                        out_last  <= 1'b0;
                    end else begin
                        mask <= mask_next;
                    end
                end
                StSend: begin
                    if (final_xfer) begin
                        state      <= StCollect;
                        mask       <= in_valid;
                        rd_ptr     <= '0;
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        out_data   <= '0;
                        frame_done <= 1'b1;
                    end else if (xfer) begin
                        rd_ptr   <= next_ptr;
                        out_data <= OUT_WIDTH'(act_buf[next_ptr]);
                        out_last <= (next_ptr == LastIdx);
                    end
                end
                default: state <= StCollect;
            endcase
        end
    end

    assign out_idx = rd_ptr;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: directed vector table followed by random traffic
// checked against a queue-based frame model.
module tb_layer_out_serializer;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int OW = 16;
    localparam int XW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*IW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [XW-1:0]   out_idx;
    logic            out_last;
    logic            frame_done;
    logic            overflow;
    logic            clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    layer_out_serializer #(
        .NUM_NEURONS(N),
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .IDX_WIDTH  (XW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_done(frame_done),
        .overflow  (overflow),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    // Frame model: words waiting to be sent, plus a partial frame being gathered.
    logic [IW-1:0] q[$];
    logic [IW-1:0] mbuf [N];
    logic [N-1:0]  got;
    bit            m_ovf;
    bit            m_fd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit was_collect, xfer, final_x, drop;
        if (rst) begin
            q.delete();
            got   = '0;
            m_ovf = 1'b0;
            m_fd  = 1'b0;
            return;
        end
        was_collect = (q.size() == 0);
        xfer        = !was_collect && out_ready;
        final_x     = xfer && (q.size() == 1);
        drop        = !was_collect && !final_x && (in_valid != '0);
        m_fd        = final_x;
        if (drop) m_ovf = 1'b1;
        else if (clr_err) m_ovf = 1'b0;
        if (was_collect || final_x) begin
            for (int k = 0; k < N; k++) begin
                if (in_valid[k]) begin
                    mbuf[k] = in_data[k*IW +: IW];
                    got[k]  = 1'b1;
                end
            end
        end
        if (xfer) void'(q.pop_front());
        if (was_collect && got == '1) begin
            for (int k = 0; k < N; k++) q.push_back(mbuf[k]);
            got = '0;
        end
    endtask

    task automatic model_check();
        bit v;
        v = (q.size() != 0);
        chk("model_valid", 32'(out_valid), 32'(v));
        chk("model_frame_done", 32'(frame_done), 32'(m_fd));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        if (v) begin
            chk("model_data", 32'(out_data), 32'(q[0]));
            chk("model_idx", 32'(out_idx), 32'(N - q.size()));
            chk("model_last", 32'(out_last), 32'(q.size() == 1));
        end else begin
            chk("model_idx_idle", 32'(out_idx), 32'd0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  iv;
        logic [N*IW-1:0] data;
        logic          rdy;
        logic          clr;
        logic          e_v;
        logic [OW-1:0] e_d;
        logic [XW-1:0] e_idx;
        logic          e_last;
        logic          e_fd;
        logic          e_ovf;
    } vec_t;

    vec_t vt [26];

    initial begin
        //          rst  iv       data                    rdy   clr   v     d         idx   last  fd    ovf
        // single frame, all at once
        vt[0]  = '{1'b0, 4'b1111, 64'h0044_0033_0022_0011, 1'b1, 1'b0, 1'b1, 16'h0011, 2'd0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0022, 2'd1, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0033, 2'd2, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0044, 2'd3, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b0, 1'b0};
        // staggered capture with duplicate on neuron 0
        vt[6]  = '{1'b0, 4'b0100, 64'h0000_0033_0000_0000, 1'b0, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_0011, 1'b0, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 4'b1000, 64'h0044_0000_0000_0000, 1'b0, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_0099, 1'b0, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 4'b0010, 64'h0000_0000_0022_0000, 1'b0, 1'b0, 1'b1, 16'h0099, 2'd0, 1'b0, 1'b0, 1'b0};
        // backpressure, overflow, clr_err against a concurrent drop
        vt[11] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0022, 2'd1, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 4'b0000, 64'h0,                   1'b0, 1'b0, 1'b1, 16'h0022, 2'd1, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b0, 4'b0000, 64'h0,                   1'b0, 1'b0, 1'b1, 16'h0022, 2'd1, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0033, 2'd2, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b0, 4'b0010, 64'h0000_0000_dead_0000, 1'b0, 1'b0, 1'b1, 16'h0033, 2'd2, 1'b0, 1'b0, 1'b1};
        vt[16] = '{1'b0, 4'b0100, 64'h0000_beef_0000_0000, 1'b1, 1'b1, 1'b1, 16'h0044, 2'd3, 1'b1, 1'b0, 1'b1};
        vt[17] = '{1'b0, 4'b0000, 64'h0,                   1'b0, 1'b1, 1'b1, 16'h0044, 2'd3, 1'b1, 1'b0, 1'b0};
        // full capture on the final transfer
        vt[18] = '{1'b0, 4'b1111, 64'h0088_0077_0066_0055, 1'b1, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b1, 1'b0};
        vt[19] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0055, 2'd0, 1'b0, 1'b0, 1'b0};
        vt[20] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0066, 2'd1, 1'b0, 1'b0, 1'b0};
        vt[21] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h0077, 2'd2, 1'b0, 1'b0, 1'b0};
        // reset mid-frame after two transfers
        vt[22] = '{1'b1, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b0, 1'b0};
        vt[23] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b0, 16'h0,    2'd0, 1'b0, 1'b0, 1'b0};
        vt[24] = '{1'b0, 4'b1111, 64'h00a4_00a3_00a2_00a1, 1'b1, 1'b0, 1'b1, 16'h00a1, 2'd0, 1'b0, 1'b0, 1'b0};
        vt[25] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 1'b0, 1'b1, 16'h00a2, 2'd1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b0; clr_err = 1'b0;
        q.delete(); got = '0; m_ovf = 1'b0; m_fd = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_idx", 32'(out_idx), 32'd0);
        chk("reset_last", 32'(out_last), 32'd0);
        chk("reset_fd", 32'(frame_done), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 26; i++) begin
            rst = vt[i].rst; in_valid = vt[i].iv; in_data = vt[i].data;
            out_ready = vt[i].rdy; clr_err = vt[i].clr;
            cycle();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_v));
            chk($sformatf("vec%0d_fd", i), 32'(frame_done), 32'(vt[i].e_fd));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].e_ovf));
            chk($sformatf("vec%0d_idx", i), 32'(out_idx), 32'(vt[i].e_idx));
            chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vt[i].e_last));
            if (vt[i].e_v) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].e_d));
        end

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                in_valid[k] = ($urandom_range(0, 5) == 0);
                in_data[k*IW +: IW] = IW'($urandom);
            end
            if ($urandom_range(0, 9) == 0) in_valid = '1;
            out_ready = ($urandom_range(0, 9) < 7);
            clr_err   = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
